// File: rtl/draw_sprite_engine.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite in ROM in raster order and emits
// one pixel write per ROM word, with optional horizontal mirroring and colour keying.
module draw_sprite_engine #(
  parameter int                   SPR_W      = 85,
  parameter int                   SPR_H      = 75,
  parameter int                   ADDR_W     = 13,
  parameter int                   COLOUR_W   = 3,
  parameter int                   ROM_LAT    = 1,
  parameter int                   KEY_EN     = 1,
  parameter logic [COLOUR_W-1:0]  KEY_COLOUR = 3'b111
) (
  input  logic                clock_all,
  input  logic                reset_all,
  input  logic                start,
  input  logic [8:0]          x_,
  input  logic [7:0]          y_,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                mirror_x,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic                plot,
  output logic [8:0]          out_x,
  output logic [7:0]          out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                busy,
  output logic                done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] WM1_A    = ADDR_W'(SPR_W - 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(SPR_H - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(ROM_LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [ADDR_W-1:0]   row_base;
  logic                mirror_r;
  logic [8:0]          x_r;
  logic [7:0]          y_r;
  logic [2:0]          drain_cnt;
  logic                issue_v;
  logic [8:0]          issue_x;
  logic [7:0]          issue_y;

  logic [ROM_LAT:1]        pipe_v;
  logic [ROM_LAT:1][8:0]   pipe_x;
  logic [ROM_LAT:1][7:0]   pipe_y;
  logic                    key_hit;

  // row_base tracks base + row*SPR_W so addresses never need a multiplier;
  // issue_* carries the screen coordinate of the address presented this cycle.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      rom_addr  <= '0;
      mirror_r  <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      drain_cnt <= '0;
      issue_v   <= 1'b0;
      issue_x   <= '0;
      issue_y   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            mirror_r <= mirror_x;
            x_r      <= x_;
            y_r      <= y_;
            col      <= '0;
            row      <= '0;
            row_base <= base_addr;
            rom_addr <= mirror_x ? base_addr + WM1_A : base_addr;
            issue_v  <= 1'b1;
            issue_x  <= x_;
            issue_y  <= y_;
          end
        end
        FETCH: begin
          if (col == COL_LAST) begin
            if (row == ROW_LAST) begin
              state     <= DRAIN;
              drain_cnt <= '0;
              issue_v   <= 1'b0;
            end else begin
              col      <= '0;
              row      <= row + 1'b1;
              row_base <= row_base + W_A;
              rom_addr <= mirror_r ? row_base + W_A + WM1_A : row_base + W_A;
              issue_x  <= x_r;
              issue_y  <= y_r + 8'(row) + 8'd1;
            end
          end else begin
            col      <= col + 1'b1;
            rom_addr <= mirror_r ? rom_addr - ADDR_W'(1) : rom_addr + ADDR_W'(1);
            issue_x  <= x_r + 9'(col) + 9'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line so the coordinates arrive in the same cycle as rom_q.
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      pipe_v <= '0;
      pipe_x <= '0;
      pipe_y <= '0;
    end else begin
      pipe_v[1] <= issue_v;
      pipe_x[1] <= issue_x;
      pipe_y[1] <= issue_y;
      for (int i = 2; i <= ROM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end

  assign key_hit    = (KEY_EN != 0) && (rom_q == KEY_COLOUR);
  assign plot       = pipe_v[ROM_LAT] && !key_hit;
  assign out_x      = pipe_x[ROM_LAT];
  assign out_y      = pipe_y[ROM_LAT];
  assign out_colour = pipe_v[ROM_LAT] ? rom_q : '0;

endmodule
